// File: rtl/seg_scan_reader_if.sv
// Bus bundle between a multiplexed 7-segment display driver (master) and the scan reader (slave).
// Carries the segment/digit-select pins plus the reconstructed frame outputs.
interface seg_scan_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          a_g;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] value;
    logic                frame_valid;
    logic                frame_err;
    logic [DIGITS-1:0]   blank_mask;

    modport master (
        output a_g, dig_sel,
        input  value, frame_valid, frame_err, blank_mask
    );

    modport slave (
        input  a_g, dig_sel,
        output value, frame_valid, frame_err, blank_mask
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Reconstructs a multi-digit BCD value from multiplexed 7-segment pins via sync, stability filter and frame assembly.
// Define SEG_ACTIVE_LOW_EN for common-anode displays (segment and digit-select pins inverted).
module seg_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_reader_if.slave     scan_if
);

    localparam int SW = DIGITS + 7;
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]       raw_in;
    logic [SW-1:0]       sync1_q, sync2_q, prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                dwell_q, dwell_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                fv_q, fv_d;
    logic                ferr_q, ferr_d;
    logic [DIGITS-1:0]   bmask_q, bmask_d;

    logic [DIGITS-1:0]   s_sel;
    logic [6:0]          s_seg;
    logic                same, onehot, capture;
    logic [3:0]          seg_nib;
    logic                seg_err, seg_blank;

`ifdef SEG_ACTIVE_LOW_EN
    assign raw_in = ~{scan_if.dig_sel, scan_if.a_g};
`else
    assign raw_in = {scan_if.dig_sel, scan_if.a_g};
`endif

    assign s_sel = sync2_q[SW-1:7];
    assign s_seg = sync2_q[6:0];

    always_comb begin
        seg_nib   = 4'hE;
        seg_err   = 1'b1;
        seg_blank = 1'b0;
        case (s_seg)
            7'h7E: begin seg_nib = 4'h0; seg_err = 1'b0; end
            7'h30: begin seg_nib = 4'h1; seg_err = 1'b0; end
            7'h6D: begin seg_nib = 4'h2; seg_err = 1'b0; end
            7'h79: begin seg_nib = 4'h3; seg_err = 1'b0; end
            7'h33: begin seg_nib = 4'h4; seg_err = 1'b0; end
            7'h5B: begin seg_nib = 4'h5; seg_err = 1'b0; end
            7'h5F: begin seg_nib = 4'h6; seg_err = 1'b0; end
            7'h70: begin seg_nib = 4'h7; seg_err = 1'b0; end
            7'h7F: begin seg_nib = 4'h8; seg_err = 1'b0; end
            7'h7B: begin seg_nib = 4'h9; seg_err = 1'b0; end
            7'h00: begin seg_nib = 4'hF; seg_err = 1'b0; seg_blank = 1'b1; end
            default: ;
        endcase
    end

    // A dwell is one unbroken run of identical one-hot samples; it yields exactly one capture
    // once STABLE_CYCLES identical samples have been seen.
    always_comb begin
        same   = (sync2_q == prev_q);
        onehot = (s_sel != '0) && ((s_sel & (s_sel - DIGITS'(1))) == '0);

        if (same && onehot)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        else
            cnt_d = '0;

        capture = onehot && (cnt_d == CNT_MAX) && !(same && dwell_q);
        dwell_d = capture || (same && onehot && dwell_q);

        shadow_d = shadow_q;
        mask_d   = mask_q;
        err_d    = err_q;
        blank_d  = blank_q;
        value_d  = value_q;
        fv_d     = 1'b0;
        ferr_d   = ferr_q;
        bmask_d  = bmask_q;

        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (s_sel[i]) begin
                    shadow_d[4*i +: 4] = seg_nib;
                    mask_d[i]          = 1'b1;
                    err_d[i]           = seg_err;
                    blank_d[i]         = seg_blank;
                end
            end
            if (&mask_d) begin
                value_d = shadow_d;
                fv_d    = 1'b1;
                ferr_d  = |err_d;
                bmask_d = blank_d;
                mask_d  = '0;
                err_d   = '0;
                blank_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            dwell_q  <= 1'b0;
            shadow_q <= '0;
            mask_q   <= '0;
            err_q    <= '0;
            blank_q  <= '0;
            value_q  <= '0;
            fv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            bmask_q  <= '0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            blank_q  <= blank_d;
            value_q  <= value_d;
            fv_q     <= fv_d;
            ferr_q   <= ferr_d;
            bmask_q  <= bmask_d;
        end
    end

    assign scan_if.value       = value_q;
    assign scan_if.frame_valid = fv_q;
    assign scan_if.frame_err   = ferr_q;
    assign scan_if.blank_mask  = bmask_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed self-checking bench for seg_scan_reader (DIGITS=4, STABLE_CYCLES=3).
// Pins are driven inverted when SEG_ACTIVE_LOW_EN is defined, so expectations are the same in both builds.
module tb_seg_scan_reader;

    logic clk;
    logic rst_n;

    int checkCount;
    int errorCount;
    int frameCount;
    logic [15:0] lastValue;
    logic        lastErr;
    logic [3:0]  lastBlank;
    int framesBefore;

    seg_scan_reader_if #(.DIGITS(4)) scanIf ();

    seg_scan_reader #(
        .DIGITS(4),
        .STABLE_CYCLES(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_if (scanIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every frame strobe so scenarios can count frames and inspect the last one
    always @(negedge clk) begin
        if (scanIf.frame_valid) begin
            frameCount = frameCount + 1;
            lastValue  = scanIf.value;
            lastErr    = scanIf.frame_err;
            lastBlank  = scanIf.blank_mask;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one logical (active-high) pattern for the given number of clock cycles
    task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
`ifdef SEG_ACTIVE_LOW_EN
        scanIf.dig_sel = ~sel;
        scanIf.a_g     = ~seg;
`else
        scanIf.dig_sel = sel;
        scanIf.a_g     = seg;
`endif
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        frameCount = 0;
        lastValue  = '0;
        lastErr    = 1'b0;
        lastBlank  = '0;
        rst_n      = 1'b0;
        applyStimulus(4'b0000, 7'h00, 3);

        checkOutput("reset_value", 32'(scanIf.value), 32'h0);
        checkOutput("reset_valid", 32'(scanIf.frame_valid), 32'h0);
        checkOutput("reset_err", 32'(scanIf.frame_err), 32'h0);
        checkOutput("reset_blank", 32'(scanIf.blank_mask), 32'h0);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 7'h00, 4);

        $display("[TB] scan 8,3,1,0");
        applyStimulus(4'b0001, 7'h7F, 6);
        applyStimulus(4'b0010, 7'h79, 6);
        applyStimulus(4'b0100, 7'h30, 6);
        applyStimulus(4'b1000, 7'h7E, 6);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s1_frames", 32'(frameCount), 32'd1);
        checkOutput("s1_value", 32'(lastValue), 32'h0138);
        checkOutput("s1_err", 32'(lastErr), 32'h0);
        checkOutput("s1_blank", 32'(lastBlank), 32'h0);
        checkOutput("s1_held", 32'(scanIf.value), 32'h0138);

        $display("[TB] long dwell on digit 1");
        framesBefore = frameCount;
        applyStimulus(4'b0010, 7'h5B, 20);
        applyStimulus(4'b0001, 7'h7E, 6);
        applyStimulus(4'b0100, 7'h7E, 6);
        applyStimulus(4'b0000, 7'h00, 6);
        checkOutput("s2_partial", 32'(frameCount - framesBefore), 32'd0);
        applyStimulus(4'b1000, 7'h7E, 6);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s2_frames", 32'(frameCount - framesBefore), 32'd1);
        checkOutput("s2_value", 32'(lastValue), 32'h0050);

        $display("[TB] glitch filtering");
        framesBefore = frameCount;
        applyStimulus(4'b0001, 7'h7E, 6);
        applyStimulus(4'b0010, 7'h7E, 6);
        applyStimulus(4'b1000, 7'h7E, 6);
        applyStimulus(4'b0100, 7'h6D, 2);
        applyStimulus(4'b0100, 7'h33, 4);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s3_frames", 32'(frameCount - framesBefore), 32'd1);
        checkOutput("s3_value", 32'(lastValue), 32'h0400);

        $display("[TB] illegal and blank digits");
        framesBefore = frameCount;
        applyStimulus(4'b1000, 7'h01, 6);
        applyStimulus(4'b0100, 7'h00, 6);
        applyStimulus(4'b0010, 7'h7B, 6);
        applyStimulus(4'b0001, 7'h7B, 6);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s4_frames", 32'(frameCount - framesBefore), 32'd1);
        checkOutput("s4_value", 32'(lastValue), 32'hEF99);
        checkOutput("s4_err", 32'(lastErr), 32'h1);
        checkOutput("s4_blank", 32'(lastBlank), 32'h4);

        $display("[TB] multi-hot select and mid-frame reset");
        framesBefore = frameCount;
        applyStimulus(4'b0100, 7'h30, 6);
        applyStimulus(4'b1000, 7'h30, 6);
        applyStimulus(4'b0011, 7'h7E, 10);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s5_multihot", 32'(frameCount - framesBefore), 32'd0);
        applyStimulus(4'b0001, 7'h30, 6);
        applyStimulus(4'b0000, 7'h00, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_value", 32'(scanIf.value), 32'h0);
        checkOutput("s5_rst_err", 32'(scanIf.frame_err), 32'h0);
        checkOutput("s5_rst_blank", 32'(scanIf.blank_mask), 32'h0);
        applyStimulus(4'b0000, 7'h00, 2);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 7'h00, 2);
        framesBefore = frameCount;
        applyStimulus(4'b0001, 7'h30, 6);
        applyStimulus(4'b0010, 7'h30, 6);
        applyStimulus(4'b0100, 7'h30, 6);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s5_after_rst_partial", 32'(frameCount - framesBefore), 32'd0);
        applyStimulus(4'b1000, 7'h7B, 6);
        applyStimulus(4'b0000, 7'h00, 8);
        checkOutput("s5_frames", 32'(frameCount - framesBefore), 32'd1);
        checkOutput("s5_value", 32'(lastValue), 32'h9111);
        checkOutput("s5_err", 32'(lastErr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reader side of the multiplexed 7-segment display interface: samples the segment bus and one-hot digit-select lines and reconstructs the displayed multi-digit BCD value.
- Each pattern is qualified by an input synchronizer plus a stability filter before capture.
- A completed frame (every digit captured once) is presented on a parallel output with a one-cycle valid strobe.
- Used for display loopback checking and for recovering counter values from display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 3, consecutive identical synchronized samples required before a capture (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_g  input  7  segment bus; bit6=a, bit5=b ... bit0=g; active-high by default.
- dig_sel  input  DIGITS  digit enable, one-hot active-high; bit i selects digit i.
- value  output  4*DIGITS  captured BCD frame; digit i occupies [4i+3:4i], digit 0 least significant.
- frame_valid  output  1  one-cycle pulse when value is updated.
- frame_err  output  1  valid with frame_valid: 1 if any digit in that frame was an illegal pattern.
- blank_mask  output  DIGITS  valid with frame_valid: bit i set if digit i was blank (all segments off).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (async assert, registers clear immediately): value=0, frame_valid=0, frame_err=0, blank_mask=0. Also clears synchronizers, stability counter, captured-this-dwell flag, digit shadow, capture mask and error accumulator.
- Synchronizer: {dig_sel, a_g} passes through 2 flop stages. All later logic uses the stage-2 sample S.
- Stability filter:
  - Counter cnt compares S with the previous S.
  - If S is unchanged and dig_sel in S is exactly one-hot: cnt increments, saturating at STABLE_CYCLES-1.
  - Otherwise cnt=0 and the dwell flag clears.
  - dig_sel all-zero or multi-hot never captures.
- Capture:
  - Occurs on the edge where S has been identical for STABLE_CYCLES consecutive samples and the dwell flag is clear. That edge sets the dwell flag.
  - Exactly one capture per dwell; holding a pattern longer does not recapture.
  - Pin-to-capture latency = 2 + STABLE_CYCLES - 1 edges after the pins settle.
- Pattern decode (a..g):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - 00: blank; stored nibble 4'hF; blank flag set; not an error.
  - Any other code: stored nibble 4'hE; error flag set for that digit.
- Capture writes the nibble into shadow slot i and sets mask bit i.
  - Recapturing a digit already in the mask overwrites its nibble and flags; no error results.
- Frame completion:
  - On the capture edge where the mask becomes all-ones, value is loaded with the full shadow including the new digit.
  - Same edge: frame_valid=1 for one cycle; frame_err = OR of the per-digit error flags; blank_mask = per-digit blank flags.
  - Mask and flags clear on that edge.
  - value holds until the next completed frame.
- Scan order is irrelevant; any order completes a frame.
- Reset mid-frame discards the partial frame; the first frame after reset requires every digit again.
- DIGITS=1: every capture completes a frame.

Optional Feature:
- Macro SEG_ACTIVE_LOW_EN.
- When defined: a_g and dig_sel are inverted before the synchronizer (common-anode display, low = lit/selected). All decode values above then apply to the inverted bus.
- When undefined: inputs are used as-is, active-high.

Test Plan:
- Reset then scan digits 0..3 with a_g=7F,79,30,7E, each held 6 cycles → single frame_valid, value=16'h0138, frame_err=0, blank_mask=0.
- Hold digit 1 with a_g=5B for 20 cycles after the frame → exactly one capture. Then scan digits 0,2,3 with 7E → value=16'h0050 on completion.
- Glitch: digit 2 pattern 6D held only 2 cycles, then changed to 33 held 4 cycles, others 7E → value=16'h0400. The 6D pattern is never captured.
- Illegal/blank: digit 3 a_g=01, digit 2 a_g=00, digits 1,0 = 7B → value=16'hEF99, frame_err=1, blank_mask=4'b0100.
- dig_sel=4'b0011 held 10 cycles → no capture, mask unchanged. Assert rst_n=0 after 3 of 4 digits captured → outputs 0 immediately; frame_valid absent until all 4 digits are rescanned.
- With SEG_ACTIVE_LOW_EN: drive inverted buses (a_g=~7E etc.) with the first scenario's digit sequence → identical value=16'h0138.
